modmul_wordserial: RTL and testbench



---
 rtl/modmul_wordserial.sv | 106 ++++++++++
 tb/tb_modmul_wordserial.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/modmul_wordserial.sv
// rtl/modmul_wordserial.sv - word-serial unsigned LOGQ x LOGQ multiplier with valid/ready handshake
// Consumes one WORD_SIZE-bit digit of B per BUSY cycle, LSB digit first.
module modmul_wordserial #(
   parameter int LOGQ      = 8,
   parameter int WORD_SIZE = 4,
   parameter int NUM_WORDS = (LOGQ + WORD_SIZE - 1) / WORD_SIZE
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [LOGQ-1:0]     A,
   input  logic [LOGQ-1:0]     B,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [2*LOGQ-1:0]   P
);

   localparam int PW  = 2 * LOGQ;
   localparam int PPW = LOGQ + WORD_SIZE;
   localparam int BW  = NUM_WORDS * WORD_SIZE;
   localparam int CW  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

   if (LOGQ < 1) begin : g_bad_logq
      $error("modmul_wordserial: LOGQ must be >= 1");
   end
   if (WORD_SIZE < 1 || WORD_SIZE > LOGQ) begin : g_bad_word_size
      $error("modmul_wordserial: WORD_SIZE must be in 1..LOGQ");
   end
   if (NUM_WORDS != (LOGQ + WORD_SIZE - 1) / WORD_SIZE) begin : g_bad_num_words
      $error("modmul_wordserial: NUM_WORDS must equal ceil(LOGQ/WORD_SIZE)");
   end

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t          state;
   state_t          next_state;
   logic [LOGQ-1:0] a_reg;
   logic [BW-1:0]   b_reg;
   logic [PW-1:0]   acc;
   logic [CW-1:0]   cnt;
   logic [PPW-1:0]  pp;
   logic [PW-1:0]   pp_shifted;
   logic            load;
   logic            last;

   // The shifted partial product may drop high bits only when they are provably zero.
   assign pp         = PPW'(a_reg) * PPW'(b_reg[WORD_SIZE-1:0]);
   assign pp_shifted = PW'(pp) << (32'(cnt) * 32'(WORD_SIZE));
   assign last       = (cnt == CW'(NUM_WORDS - 1));
   assign load       = in_valid && in_ready;
   assign P          = acc;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (in_valid) next_state = BUSY;
         BUSY: if (last) next_state = DONE;
         DONE: if (out_ready) next_state = in_valid ? BUSY : IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: in_ready = 1'b1;
         DONE: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
         end
         default: begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_reg <= '0;
         b_reg <= '0;
         acc   <= '0;
         cnt   <= '0;
      end else if (load) begin
         a_reg <= A;
         b_reg <= BW'(B);
         acc   <= '0;
         cnt   <= '0;
      end else if (state == BUSY) begin
         acc   <= acc + pp_shifted;
         b_reg <= b_reg >> WORD_SIZE;
         cnt   <= cnt + CW'(1);
      end
   end

endmodule

// File: tb/tb_modmul_wordserial.sv
// tb/tb_modmul_wordserial.sv - scoreboard bench for modmul_wordserial at three widths
module tb_modmul_wordserial;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        iv8, ir8, ov8, or8;
   logic [7:0]  a8, b8;
   logic [15:0] p8;
   logic        iv7, ir7, ov7, or7;
   logic [6:0]  a7, b7;
   logic [13:0] p7;
   logic        iv32, ir32, ov32, or32;
   logic [31:0] a32, b32;
   logic [63:0] p32;

   modmul_wordserial #(.LOGQ(8), .WORD_SIZE(4), .NUM_WORDS(2)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .A(a8), .B(b8),
      .out_valid(ov8), .out_ready(or8), .P(p8));
   modmul_wordserial #(.LOGQ(7), .WORD_SIZE(3), .NUM_WORDS(3)) u_dut7 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv7), .in_ready(ir7), .A(a7), .B(b7),
      .out_valid(ov7), .out_ready(or7), .P(p7));
   modmul_wordserial #(.LOGQ(32), .WORD_SIZE(16), .NUM_WORDS(2)) u_dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .A(a32), .B(b32),
      .out_valid(ov32), .out_ready(or32), .P(p32));

   logic [15:0] q8[$];
   logic [63:0] q32[$];
   int          hs8[$];
   logic        hold8 = 1'b0;
   logic [15:0] held8 = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard for the 8-bit instance: pops on each transfer, checks hold while stalled.
   always @(negedge clk) begin
      if (!rst_n) begin
         hold8 = 1'b0;
         q8.delete();
      end else begin
         if (hold8) begin
            chk("hold_valid8", 64'(ov8), 64'd1);
            chk("hold_p8", 64'(p8), 64'(held8));
         end
         if (ov8 && or8) begin
            hs8.push_back(cyc);
            if (q8.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_p8 actual=%0d required=no transfer", p8);
            end else begin
               chk("p8", 64'(p8), 64'(q8.pop_front()));
            end
         end
         hold8 = ov8 && !or8;
         held8 = p8;
      end
   end

   always @(negedge clk) begin
      if (rst_n && ov32 && or32) begin
         if (q32.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_p32 actual=%0d required=no transfer", p32);
         end else begin
            chk("p32", p32, q32.pop_front());
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] p;
      int          stall;
   } vec_t;
   vec_t tv[7];

   logic [7:0]  pa[3];
   logic [7:0]  pb[3];
   logic [15:0] pp[3];
   logic [6:0]  ta7[2];
   logic [6:0]  tb7[2];
   logic [13:0] tp7[2];

   initial begin
      int   lat, guard, k;
      logic busy_ok, ov_seen;

      rst_n = 1'b0;
      iv8 = 0; or8 = 0; a8 = 0; b8 = 0;
      iv7 = 0; or7 = 0; a7 = 0; b7 = 0;
      iv32 = 0; or32 = 0; a32 = 0; b32 = 0;
      repeat (3) step();
      rst_n = 1'b1;
      chk("reset_in_ready8", 64'(ir8), 64'd1);
      chk("reset_out_valid8", 64'(ov8), 64'd0);
      chk("reset_p8", 64'(p8), 64'd0);
      chk("reset_in_ready7", 64'(ir7), 64'd1);
      chk("reset_out_valid32", 64'(ov32), 64'd0);

      tv[0] = '{8'd255, 8'd255, 16'd65025, 10};
      tv[1] = '{8'hB7,  8'h00,  16'd0,     2};
      tv[2] = '{8'h00,  8'hFF,  16'd0,     0};
      tv[3] = '{8'd1,   8'hA5,  16'h00A5,  1};
      tv[4] = '{8'd15,  8'd17,  16'd255,   0};
      tv[5] = '{8'h80,  8'd2,   16'd256,   3};
      tv[6] = '{8'd13,  8'hF0,  16'd3120,  1};

      for (int i = 0; i < 7; i++) begin
         a8 = tv[i].a;
         b8 = tv[i].b;
         iv8 = 1'b1;
         chk("in_ready_idle", 64'(ir8), 64'd1);
         q8.push_back(tv[i].p);
         step();
         iv8 = 1'b0;
         busy_ok = 1'b1;
         lat = 0;
         while (!ov8 && lat < 50) begin
            if (ir8) busy_ok = 1'b0;
            step();
            lat++;
         end
         chk("latency8", 64'(lat), 64'd2);
         chk("in_ready_busy", 64'(busy_ok), 64'd1);
         iv8 = 1'b1;
         a8 = 8'h11;
         b8 = 8'h22;
         for (int s = 0; s < tv[i].stall; s++) begin
            chk("in_ready_stall", 64'(ir8), 64'd0);
            step();
         end
         iv8 = 1'b0;
         or8 = 1'b1;
         step();
         or8 = 1'b0;
         chk("single_transfer", 64'(ov8), 64'd0);
         chk("idle_after_transfer", 64'(ir8), 64'd1);
         chk("queue_drained", 64'(q8.size()), 64'd0);
      end

      // Back-to-back stream: reload from DONE must not insert an idle cycle.
      pa[0] = 8'd3;   pb[0] = 8'd5;   pp[0] = 16'd15;
      pa[1] = 8'd200; pb[1] = 8'd201; pp[1] = 16'd40200;
      pa[2] = 8'd255; pb[2] = 8'd1;   pp[2] = 16'd255;
      hs8.delete();
      or8 = 1'b1;
      k = 0;
      guard = 0;
      iv8 = 1'b1;
      a8 = pa[0];
      b8 = pb[0];
      while (k < 3 && guard < 100) begin
         if (ir8) begin
            q8.push_back(pp[k]);
            k++;
            step();
            if (k < 3) begin
               a8 = pa[k];
               b8 = pb[k];
            end
         end else begin
            step();
         end
         guard++;
      end
      iv8 = 1'b0;
      guard = 0;
      while (q8.size() != 0 && guard < 50) begin
         step();
         guard++;
      end
      chk("b2b_drained", 64'(q8.size()), 64'd0);
      chk("b2b_count", 64'(hs8.size()), 64'd3);
      if (hs8.size() == 3) begin
         chk("b2b_gap1", 64'(hs8[1] - hs8[0]), 64'd3);
         chk("b2b_gap2", 64'(hs8[2] - hs8[1]), 64'd3);
      end
      or8 = 1'b0;
      step();

      // Reset in the second BUSY cycle discards the product.
      a8 = 8'd9;
      b8 = 8'd9;
      iv8 = 1'b1;
      step();
      iv8 = 1'b0;
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("abort_out_valid", 64'(ov8), 64'd0);
      chk("abort_in_ready", 64'(ir8), 64'd1);
      ov_seen = 1'b0;
      for (int s = 0; s < 4; s++) begin
         if (ov8) ov_seen = 1'b1;
         step();
      end
      chk("abort_never_valid", 64'(ov_seen), 64'd0);
      a8 = 8'd16;
      b8 = 8'd16;
      iv8 = 1'b1;
      q8.push_back(16'd256);
      step();
      iv8 = 1'b0;
      lat = 0;
      while (!ov8 && lat < 50) begin
         step();
         lat++;
      end
      chk("post_reset_latency", 64'(lat), 64'd2);
      or8 = 1'b1;
      step();
      or8 = 1'b0;
      chk("post_reset_drained", 64'(q8.size()), 64'd0);

      // Padded top digit: LOGQ=7 with three 3-bit digits.
      ta7[0] = 7'd127; tb7[0] = 7'd127; tp7[0] = 14'd16129;
      ta7[1] = 7'd85;  tb7[1] = 7'd42;  tp7[1] = 14'd3570;
      for (int i = 0; i < 2; i++) begin
         a7 = ta7[i];
         b7 = tb7[i];
         iv7 = 1'b1;
         step();
         iv7 = 1'b0;
         lat = 0;
         while (!ov7 && lat < 50) begin
            step();
            lat++;
         end
         chk("latency7", 64'(lat), 64'd3);
         chk("p7", 64'(p7), 64'(tp7[i]));
         or7 = 1'b1;
         step();
         or7 = 1'b0;
         chk("transfer7", 64'(ov7), 64'd0);
      end

      // Random regression at LOGQ=32, streaming with out_ready held high.
      or32 = 1'b1;
      k = 0;
      guard = 0;
      iv32 = 1'b1;
      a32 = $urandom;
      b32 = $urandom;
      while (k < 10000 && guard < 40000) begin
         if (ir32) begin
            q32.push_back(64'(a32) * 64'(b32));
            k++;
            step();
            a32 = $urandom;
            b32 = $urandom;
         end else begin
            step();
         end
         guard++;
      end
      iv32 = 1'b0;
      chk("rand_accepted", 64'(k), 64'd10000);
      guard = 0;
      while (q32.size() != 0 && guard < 50) begin
         step();
         guard++;
      end
      chk("rand_drained", 64'(q32.size()), 64'd0);
      or32 = 1'b0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
